// File: rtl/umi_regif_arb.sv
`default_nettype none
// ============================================================================
// Module   : umi_regif_arb
// Purpose  : Round-robin arbiter sharing one reg_* register-file port among N
//            masters, with grant held to completion and a stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module umi_regif_arb #(
   parameter  int N       = 2,
   parameter  int AW      = 64,
   parameter  int RW      = 32,
   parameter  int TIMEOUT = 256,
   localparam int GW      = $clog2(N)
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [N-1:0]      req_write,
   input  logic [N-1:0]      req_read,
   input  logic [N*AW-1:0]   req_addr,
   input  logic [N*RW-1:0]   req_wrdata,
   input  logic [N*2-1:0]    req_prot,
   output logic [N-1:0]      req_ready,
   output logic [RW-1:0]     req_rddata,
   output logic [N*2-1:0]    req_err,
   output logic              reg_write,
   output logic              reg_read,
   output logic [AW-1:0]     reg_addr,
   output logic [RW-1:0]     reg_wrdata,
   output logic [1:0]        reg_prot,
   input  logic              reg_ready,
   input  logic [RW-1:0]     reg_rddata,
   input  logic [1:0]        reg_err,
   output logic              busy,
   output logic [GW-1:0]     grant_id
);

   localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] c_TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [0:0]    c_IDLE  = 1'b0;
   localparam logic [0:0]    c_BUSY  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [GW-1:0] ptr_q,   ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [N-1:0]  w_req_act;
   logic          w_any_req;
   logic          w_hi_found;
   logic [GW-1:0] w_hi_idx, w_lo_idx, w_winner;
   logic          w_g_write, w_g_read, w_gnt_act;
   logic [AW-1:0] w_g_addr;
   logic [RW-1:0] w_g_wrdata;
   logic [1:0]    w_g_prot;
   logic [GW-1:0] w_gnt_next;
   logic          w_in_busy, w_done, w_tmo, w_leave;

   assign w_req_act = req_write | req_read;
   assign w_any_req = |w_req_act;

   // Round-robin pick: lowest active index at or above ptr, else lowest active overall.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_req_act[i]) begin
            w_lo_idx = GW'(i);
         end
         if (w_req_act[i] && (GW'(i) >= ptr_q)) begin
            w_hi_found = 1'b1;
            w_hi_idx   = GW'(i);
         end
      end
      w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   always_comb begin
      w_g_write  = 1'b0;
      w_g_read   = 1'b0;
      w_g_addr   = '0;
      w_g_wrdata = '0;
      w_g_prot   = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q == GW'(i)) begin
            w_g_write  = req_write[i];
            w_g_read   = req_read[i];
            w_g_addr   = req_addr[i*AW +: AW];
            w_g_wrdata = req_wrdata[i*RW +: RW];
            w_g_prot   = req_prot[i*2 +: 2];
         end
      end
   end

   assign w_gnt_act  = w_g_write | w_g_read;
   assign w_gnt_next = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
   assign w_in_busy  = (state_q == c_BUSY);
   assign w_done     = w_in_busy & w_gnt_act & reg_ready;
   // A completing register file always beats the watchdog in the same cycle.
   assign w_tmo      = (TIMEOUT > 0) & w_in_busy & w_gnt_act & ~reg_ready
                       & (timer_q == c_TLAST);
   assign w_leave    = ~w_gnt_act | w_done | w_tmo;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= c_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      timer_d = timer_q;
      case (state_q)
         c_IDLE: begin
            if (w_any_req) begin
               state_d = c_BUSY;
               grant_d = w_winner;
               timer_d = '0;
            end
         end
         c_BUSY: begin
            if (w_leave) begin
               state_d = c_IDLE;
               ptr_d   = w_gnt_next;
            end else if (TIMEOUT > 0) begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      reg_write  = 1'b0;
      reg_read   = 1'b0;
      reg_addr   = '0;
      reg_wrdata = '0;
      reg_prot   = '0;
      req_ready  = '0;
      req_rddata = '0;
      req_err    = '0;
      busy       = 1'b0;
      if (w_in_busy) begin
         busy       = 1'b1;
         reg_addr   = w_g_addr;
         reg_wrdata = w_g_wrdata;
         reg_prot   = w_g_prot;
         reg_write  = w_g_write & ~w_tmo;
         reg_read   = w_g_read & ~w_tmo;
         if (w_done) begin
            req_rddata = reg_rddata;
         end
         for (int i = 0; i < N; i++) begin
            if (grant_q == GW'(i)) begin
               if (w_done) begin
                  req_ready[i]     = 1'b1;
                  req_err[i*2 +: 2] = reg_err;
               end else if (w_tmo) begin
                  req_ready[i]     = 1'b1;
                  req_err[i*2 +: 2] = 2'b10;
               end
            end
         end
      end
   end

   assign grant_id = grant_q;

endmodule
`default_nettype wire
